router_odata_buf: RTL and testbench
===================================

// Module: router_odata_buf
// PURPOSE
//  Parametrised output-data buffer for the router slice; generalises the single-bit ODATA flop to a
//  WIDTH-bit, DEPTH-entry register FIFO with valid/ready handshake on both sides.
//  Sits between router crossbar output and the tile output pins. Absorbs downstream back-pressure
//  and reports occupancy and almost-full state to the router arbiter.
// PARAMETERS
//  WIDTH      8        data bits per entry (>=1)
//  DEPTH      4        entries, power of two, >=2
//  AF_THRESH  DEPTH-1  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  RESET_VAL  0        WIDTH-bit value loaded into every storage entry on reset/flush
// PORTS
//  clk        in   1                 single clock, all state updates on rising edge
//  reset      in   1                 synchronous, active-high reset
//  flush      in   1                 synchronous clear of contents (same effect as reset)
//  in_valid   in   1                 upstream word present
//  in_ready   out  1                 buffer can accept (not full)
//  in_data    in   WIDTH             upstream word
//  out_valid  out  1                 buffer non-empty
//  out_ready  in   1                 downstream accepts head word
//  out_data   out  WIDTH             head word, mem[rd_ptr]
//  count      out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  almost_full out 1                 count >= AF_THRESH
// BEHAVIOUR
//  - Storage: DEPTH x WIDTH flops, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Transfers only on these qualifiers.
//  - in_ready = (count != DEPTH); out_valid = (count != 0); both derived from registered count.
//  - push: mem[wr_ptr] <= in_data, wr_ptr++. pop: rd_ptr++. count += push - pop.
//  - Latency: word pushed in cycle N visible on out_data with out_valid=1 in cycle N+1 (no bypass).
//  - Full: in_ready=0; push blocked even if pop occurs same cycle (in_ready not combinational on out_ready).
//  - Empty: out_valid=0; out_ready ignored, no pointer or count change.
//  - Push+pop same cycle, 0<count<DEPTH: both occur, count unchanged, pointers both advance.
//  - out_data when out_valid=0: shows mem[rd_ptr] (stale or RESET_VAL); must not be consumed.
//  - Reset (priority 1) / flush (priority 2): next cycle wr_ptr=rd_ptr=0, count=0, all entries=RESET_VAL,
//    in_ready=1, out_valid=0, almost_full=0 (AF_THRESH>=1), out_data=RESET_VAL. Push/pop in the
//    same cycle as reset/flush are discarded. Applies equally mid-stream and when full.
//  - Data integrity: words leave in exact push order, no duplication or loss across pointer wrap.
//  - No combinational path from in_valid to out_valid or from out_ready to in_ready.
// TESTING
//  - Reset: assert reset 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_data=RESET_VAL.
//  - Fill/drain: push 0x11,0x22,0x33,0x44 with out_ready=0 (DEPTH=4) -> count=4, in_ready=0,
//    almost_full=1 from count 3; 5th word 0x55 not accepted; drain yields 0x11..0x44 in order.
//  - Latency: push 0xA5 into empty buffer at cycle N -> out_valid=1, out_data=0xA5 at N+1, not N.
//  - Streaming: in_valid=out_ready=1 for 20 cycles, incrementing data -> count steady at 1 after
//    first cycle, all 20 words out in order, pointers wrap 5 times without loss.
//  - Full+pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3; next cycle push+pop, count=3.
//  - Flush mid-stream: count=2, flush=1 with push and pop -> next cycle count=0, out_valid=0,
//    subsequent push 0x7E emerges first.

Source files
------------

// File: rtl/router_odata_buf.sv
// Output-data buffer between the router crossbar and the tile output pins: a WIDTH x DEPTH
// register FIFO with valid/ready on both sides, occupancy and almost-full reporting to the arbiter.
module router_odata_buf #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter int               AF_THRESH = DEPTH - 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             clear;

    // Handshake flags come only from the registered count, so neither side sees the other combinationally.
    assign in_ready    = (count_q != FULL_CNT);
    assign out_valid   = (count_q != '0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign clear       = reset | flush;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CNT);
    assign out_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps modulo DEPTH on its own.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_router_odata_buf.sv
// Directed self-checking bench for router_odata_buf at WIDTH=8, DEPTH=4, AF_THRESH=3.
module tb_router_odata_buf;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       almost_full;

    int checks;
    int errors;

    router_odata_buf #(
        .WIDTH(8),
        .DEPTH(4),
        .AF_THRESH(3),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++;
        if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            cycle();
            checks++;
            if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            checks++;
            if (almost_full !== (i + 1 >= 3)) begin
                errors++; $display("FAIL fill_almost_full[%0d] got %b exp %b", i, almost_full, (i + 1 >= 3));
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_data = 8'h55;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got %0d exp 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i]) begin
                errors++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, vals[i]);
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle got %b exp 0", out_valid); end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL latency_next_cycle got v=%b d=%h exp v=1 d=a5", out_valid, out_data);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL latency_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_empty_pop();
        out_ready = 1'b1; in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL empty_pop got c=%0d r=%b exp c=0 r=1", count, in_ready);
        end
        // Pointers must not have moved: the next push must emerge immediately.
        in_valid = 1'b1; in_data = 8'hC3;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'hC3 || count !== 3'd1) begin
            errors++; $display("FAIL empty_pop_ptr got d=%h c=%0d exp d=c3 c=1", out_data, count);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] exp_q [$];
        int received;
        received = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'h20 + 8'(i);
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    errors++; $display("FAIL stream_data[%0d] got %h", i, out_data);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                received++;
            end
            if (in_ready === 1'b1) exp_q.push_back(in_data);
            cycle();
            checks++;
            if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) begin
            errors++; $display("FAIL stream_last got v=%b d=%h exp v=1 d=33", out_valid, out_data);
        end
        received++;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (received !== 20 || count !== 3'd0) begin
            errors++; $display("FAIL stream_total got n=%0d c=%0d exp n=20 c=0", received, count);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h61 + 8'(i);
            cycle();
        end
        in_data = 8'h65; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_in_ready got %b exp 0", in_ready); end
        cycle();
        checks++;
        if (count !== 3'd3 || out_data !== 8'h62) begin
            errors++; $display("FAIL full_pop_only got c=%0d d=%h exp c=3 d=62", count, out_data);
        end
        in_data = 8'h66;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || out_data !== 8'h63) begin
            errors++; $display("FAIL full_push_pop got c=%0d d=%h exp c=3 d=63", count, out_data);
        end
        cycle();
        checks++;
        if (out_data !== 8'h64) begin errors++; $display("FAIL full_drain0 got %h exp 64", out_data); end
        cycle();
        checks++;
        if (out_data !== 8'h66) begin errors++; $display("FAIL full_drain1 got %h exp 66", out_data); end
        cycle();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h31;
        cycle();
        in_data = 8'h32;
        cycle();
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL flush_pre_count got %0d exp 2", count); end
        flush = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL flush_state got c=%0d v=%b r=%b d=%h exp c=0 v=0 r=1 d=00", count, out_valid, in_ready, out_data);
        end
        in_valid = 1'b1; in_data = 8'h7E;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7E || count !== 3'd1) begin
            errors++; $display("FAIL flush_first got v=%b d=%h c=%0d exp v=1 d=7e c=1", out_valid, out_data, count);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hD0 + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || almost_full !== 1'b1) begin
            errors++; $display("FAIL prereset_full got c=%0d af=%b exp c=4 af=1", count, almost_full);
        end
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || almost_full !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_full got c=%0d af=%b d=%h exp c=0 af=0 d=00", count, almost_full, out_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_latency();
        test_empty_pop();
        test_streaming();
        test_full_pop();
        test_flush();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
